// File: rtl/fp_conv_pkg.sv
// Shared fp32 <-> integer conversion types and constants.
// Used by the fp32 unpack front end and the fp32-to-int32 converter pipeline.
package fp_conv_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned MANT_W    = FRAC_W + 1;
  localparam int unsigned INT_W     = 32;
  localparam int unsigned SHIFT_W   = 6;
  localparam int unsigned FLAGS_W   = 3;
  localparam int unsigned FP32_BIAS = 127;

  localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_fields_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } conv_flags_t;

  typedef enum logic [2:0] {
    FC_ZERO_SMALL,
    FC_NORMAL,
    FC_OVF,
    FC_INF,
    FC_NAN
  } fp_class_t;

endpackage

// File: rtl/fp32_to_int32_pipe_if.sv
// Valid/ready stream bundle for the fp32-to-int32 converter.
//   in_valid/in_ready/in_data          : fp32 operand stream into the converter
//   out_valid/out_ready/out_data/flags : int32 result stream out of the converter
// master = producer/consumer side, slave = converter side.
interface fp32_to_int32_pipe_if;
  import fp_conv_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INT_W-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [INT_W-1:0]   out_data;
  logic [FLAGS_W-1:0] out_flags;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/fp32_unpack.sv
// Combinational fp32 field split, classification and alignment shift.
//   in_data        : packed fp32 word {sign, exp, frac}
//   sign           : operand sign
//   mant           : 24-bit significand with hidden bit restored
//   shift          : signed left-shift that aligns mant to an integer (exp - 150)
//   cls            : conversion class (small / normal / overflow / inf / nan)
//   small_inexact  : |x| < 1 and x is nonzero
//   small_round_up : 0.5 < |x| < 1, rounds to magnitude 1 under nearest-even
module fp32_unpack
  import fp_conv_pkg::*;
(
  input  logic [INT_W-1:0]          in_data,
  output logic                      sign,
  output logic [MANT_W-1:0]         mant,
  output logic signed [SHIFT_W-1:0] shift,
  output fp_class_t                 cls,
  output logic                      small_inexact,
  output logic                      small_round_up
);

  localparam logic [EXP_W-1:0] E_MAX    = '1;
  localparam logic [EXP_W-1:0] E_ONE    = EXP_W'(FP32_BIAS);
  localparam logic [EXP_W-1:0] E_HALF   = EXP_W'(FP32_BIAS - 1);
  localparam logic [EXP_W-1:0] E_INTMIN = EXP_W'(FP32_BIAS + INT_W - 1);
  localparam logic [EXP_W-1:0] E_ALIGN  = EXP_W'(FP32_BIAS + FRAC_W);

  fp32_fields_t fld;

  assign fld = in_data;

  // Field split; shift only needs to be meaningful for the normal class (-23..+8).
  always_comb begin
    sign           = fld.sign;
    mant           = {fld.exp != '0, fld.frac};
    shift          = SHIFT_W'(fld.exp - E_ALIGN);
    small_inexact  = (fld.exp != '0) || (fld.frac != '0);
    small_round_up = (fld.exp == E_HALF) && (fld.frac != '0);
  end

  // Exactly -2^31 is the only exponent-158 value that fits; it stays normal.
  always_comb begin
    cls = FC_NORMAL;
    if (fld.exp == E_MAX) begin
      cls = (fld.frac != '0) ? FC_NAN : FC_INF;
    end else if (fld.exp < E_ONE) begin
      cls = FC_ZERO_SMALL;
    end else if (fld.exp > E_INTMIN) begin
      cls = FC_OVF;
    end else if ((fld.exp == E_INTMIN) && !(fld.sign && (fld.frac == '0))) begin
      cls = FC_OVF;
    end
  end

endmodule

// File: rtl/fp32_to_int32_pipe.sv
// Two-stage pipelined fp32 to signed int32 converter with valid/ready backpressure.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of fp32_to_int32_pipe_if
//                in_* carries fp32 operands, out_* carries int32 results plus
//                {invalid, overflow, inexact} flags
// Parameters: ROUND_RNE (0 truncate, 1 nearest-even), NAN_VALUE (result for NaN).
module fp32_to_int32_pipe
  import fp_conv_pkg::*;
#(
  parameter int unsigned      ROUND_RNE = 0,
  parameter logic [INT_W-1:0] NAN_VALUE = 32'h7FFF_FFFF
)
(
  input logic                  clk,
  input logic                  reset,
  fp32_to_int32_pipe_if.slave  bus
);

  localparam bit RNE = (ROUND_RNE != 0);

  logic                      en;

  logic                      u_sign;
  logic [MANT_W-1:0]         u_mant;
  logic signed [SHIFT_W-1:0] u_shift;
  fp_class_t                 u_cls;
  logic                      u_small_inexact;
  logic                      u_small_round_up;

  logic                      s1_valid;
  logic                      s1_sign;
  logic [MANT_W-1:0]         s1_mant;
  logic signed [SHIFT_W-1:0] s1_shift;
  fp_class_t                 s1_cls;
  logic                      s1_small_inexact;
  logic                      s1_small_round_up;

  logic [SHIFT_W-1:0]        neg_shift;
  logic [2*MANT_W-1:0]       ext;
  logic [INT_W-1:0]          mag;
  logic [INT_W-1:0]          small_mag;
  logic                      guard;
  logic                      sticky;
  logic [INT_W-1:0]          res;
  conv_flags_t               flags;

  // Whole pipeline advances together unless a valid result is being held.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  fp32_unpack u_unpack (
    .in_data        (bus.in_data),
    .sign           (u_sign),
    .mant           (u_mant),
    .shift          (u_shift),
    .cls            (u_cls),
    .small_inexact  (u_small_inexact),
    .small_round_up (u_small_round_up)
  );

  // Stage 1: register classified operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid          <= 1'b0;
      s1_sign           <= 1'b0;
      s1_mant           <= '0;
      s1_shift          <= '0;
      s1_cls            <= FC_ZERO_SMALL;
      s1_small_inexact  <= 1'b0;
      s1_small_round_up <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign           <= u_sign;
        s1_mant           <= u_mant;
        s1_shift          <= u_shift;
        s1_cls            <= u_cls;
        s1_small_inexact  <= u_small_inexact;
        s1_small_round_up <= u_small_round_up;
      end
    end
  end

  // Stage 2 datapath: align, round, negate and select special results.
  // Right shifts go through a 48-bit window: top half is the integer part,
  // bit 23 the guard bit, bits 22:0 feed sticky.
  always_comb begin
    neg_shift = SHIFT_W'(-s1_shift);
    ext       = {s1_mant, {MANT_W{1'b0}}} >> neg_shift;
    mag       = '0;
    guard     = 1'b0;
    sticky    = 1'b0;
    small_mag = INT_W'(RNE && s1_small_round_up);
    res       = '0;
    flags     = '0;

    if (s1_shift >= 0) begin
      mag = {{(INT_W-MANT_W){1'b0}}, s1_mant} << s1_shift;
    end else begin
      mag    = {{(INT_W-MANT_W){1'b0}}, ext[2*MANT_W-1:MANT_W]};
      guard  = ext[MANT_W-1];
      sticky = |ext[MANT_W-2:0];
    end

    if (RNE && guard && (sticky || mag[0])) begin
      mag = mag + INT_W'(1);
    end

    unique case (s1_cls)
      FC_NAN: begin
        res           = NAN_VALUE;
        flags.invalid = 1'b1;
      end
      FC_INF, FC_OVF: begin
        res            = s1_sign ? INT_MIN : INT_MAX;
        flags.overflow = 1'b1;
      end
      FC_ZERO_SMALL: begin
        res           = s1_sign ? -small_mag : small_mag;
        flags.inexact = s1_small_inexact;
      end
      default: begin
        res           = s1_sign ? -mag : mag;
        flags.inexact = guard | sticky;
      end
    endcase
  end

  // Stage 2 output register; bubbles leave the previous data in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_flags <= '0;
    end else if (en) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data  <= res;
        bus.out_flags <= flags;
      end
    end
  end

endmodule

// File: tb/tb_fp32_to_int32_pipe.sv
// Self-checking bench: truncating and nearest-even converters driven in lockstep
// with directed vectors, plus backpressure and mid-stream reset sequences.
module tb_fp32_to_int32_pipe;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fp32_to_int32_pipe_if bus0 ();
  fp32_to_int32_pipe_if bus1 ();

  fp32_to_int32_pipe #(.ROUND_RNE(0), .NAN_VALUE(32'h7FFF_FFFF)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  fp32_to_int32_pipe #(.ROUND_RNE(1), .NAN_VALUE(32'h7FFF_FFFF)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [31:0] d0;
    logic [2:0]  f0;
    logic [31:0] d1;
    logic [2:0]  f1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] din, input logic [31:0] d0, input logic [2:0] f0,
                     input logic [31:0] d1, input logic [2:0] f1);
    vec_t v;
    v.din = din; v.d0 = d0; v.f0 = f0; v.d1 = d1; v.f1 = f1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [31:0] d);
    bus0.in_valid = v; bus0.in_data = d;
    bus1.in_valid = v; bus1.in_data = d;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  // One isolated word: accepted on the first edge, valid exactly two edges later.
  task automatic apply(input int i, input vec_t v);
    @(negedge clk);
    drive_in(1'b1, v.din);
    #1;
    chk($sformatf("v%0d_in_ready", i), 32'(bus0.in_ready), 32'd1);
    @(negedge clk);
    drive_in(1'b0, 32'h0);
    chk($sformatf("v%0d_lat1_0", i), 32'(bus0.out_valid), 32'd0);
    chk($sformatf("v%0d_lat1_1", i), 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_valid0", i), 32'(bus0.out_valid), 32'd1);
    chk($sformatf("v%0d_valid1", i), 32'(bus1.out_valid), 32'd1);
    chk($sformatf("v%0d_data_trunc", i), bus0.out_data, v.d0);
    chk($sformatf("v%0d_flags_trunc", i), 32'(bus0.out_flags), 32'(v.f0));
    chk($sformatf("v%0d_data_rne", i), bus1.out_data, v.d1);
    chk($sformatf("v%0d_flags_rne", i), 32'(bus1.out_flags), 32'(v.f1));
  endtask

  logic [31:0] stream[4];
  int          in_idx;
  int          got;
  int          stall;
  int          stall_seen;
  bit          seen;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive_in(1'b0, 32'h0);
    set_ready(1'b1);

    //   input         trunc result   flg    rne result     flg
    add(32'h3F80_0000, 32'h0000_0001, 3'b000, 32'h0000_0001, 3'b000); // 1.0
    add(32'h4060_0000, 32'h0000_0003, 3'b001, 32'h0000_0004, 3'b001); // 3.5
    add(32'hC020_0000, 32'hFFFF_FFFE, 3'b001, 32'hFFFF_FFFE, 3'b001); // -2.5
    add(32'h4020_0000, 32'h0000_0002, 3'b001, 32'h0000_0002, 3'b001); // 2.5 tie to even
    add(32'h4020_0001, 32'h0000_0002, 3'b001, 32'h0000_0003, 3'b001); // 2.5+ulp, sticky
    add(32'h3FC0_0000, 32'h0000_0001, 3'b001, 32'h0000_0002, 3'b001); // 1.5
    add(32'h3FA0_0001, 32'h0000_0001, 3'b001, 32'h0000_0001, 3'b001); // 1.25+ulp
    add(32'hC2F6_0000, 32'hFFFF_FF85, 3'b000, 32'hFFFF_FF85, 3'b000); // -123
    add(32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 32'h7FFF_FF80, 3'b000); // largest < 2^31
    add(32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 32'h7FFF_FFFF, 3'b010); // 2^31
    add(32'hCF00_0000, 32'h8000_0000, 3'b000, 32'h8000_0000, 3'b000); // -2^31 exact
    add(32'hCF00_0001, 32'h8000_0000, 3'b010, 32'h8000_0000, 3'b010); // just below -2^31
    add(32'hFF80_0000, 32'h8000_0000, 3'b010, 32'h8000_0000, 3'b010); // -inf
    add(32'h7F80_0000, 32'h7FFF_FFFF, 3'b010, 32'h7FFF_FFFF, 3'b010); // +inf
    add(32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100, 32'h7FFF_FFFF, 3'b100); // NaN
    add(32'hFFC0_0001, 32'h7FFF_FFFF, 3'b100, 32'h7FFF_FFFF, 3'b100); // negative NaN
    add(32'h0000_0001, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001); // denormal
    add(32'h8000_0000, 32'h0000_0000, 3'b000, 32'h0000_0000, 3'b000); // -0.0
    add(32'h3F00_0000, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001); // 0.5 tie to 0
    add(32'h3F40_0000, 32'h0000_0000, 3'b001, 32'h0000_0001, 3'b001); // 0.75
    add(32'hBF40_0000, 32'h0000_0000, 3'b001, 32'hFFFF_FFFF, 3'b001); // -0.75

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid0", 32'(bus0.out_valid), 32'd0);
    chk("rst_data0", bus0.out_data, 32'h0);
    chk("rst_flags0", 32'(bus0.out_flags), 32'd0);
    chk("rst_valid1", 32'(bus1.out_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);

    foreach (vecs[i]) apply(i, vecs[i]);

    // Backpressure: four back-to-back words, downstream stalls 3 cycles on first result.
    stream[0] = 32'h3F80_0000;
    stream[1] = 32'h4000_0000;
    stream[2] = 32'h4040_0000;
    stream[3] = 32'h4080_0000;
    in_idx = 0; got = 0; stall = 0; stall_seen = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (bus0.out_valid && !seen) begin
        seen  = 1'b1;
        stall = 3;
      end
      set_ready(stall == 0);
      if (in_idx < 4) drive_in(1'b1, stream[in_idx]);
      else            drive_in(1'b0, 32'h0);
      #1;
      if (stall > 0) begin
        chk("bp_in_ready_low", 32'(bus0.in_ready), 32'd0);
        chk("bp_hold_trunc", bus0.out_data, 32'd1);
        chk("bp_hold_rne", bus1.out_data, 32'd1);
        stall--;
        stall_seen++;
      end
      if (bus0.in_valid && bus0.in_ready) in_idx++;
      if (bus0.out_valid && bus0.out_ready) begin
        chk($sformatf("bp_order_trunc%0d", got), bus0.out_data, 32'(got + 1));
        chk($sformatf("bp_flags_trunc%0d", got), 32'(bus0.out_flags), 32'd0);
        chk($sformatf("bp_valid_rne%0d", got), 32'(bus1.out_valid), 32'd1);
        chk($sformatf("bp_order_rne%0d", got), bus1.out_data, 32'(got + 1));
        got++;
      end
    end
    chk("bp_delivered", 32'(got), 32'd4);
    chk("bp_stall_cycles", 32'(stall_seen), 32'd3);
    set_ready(1'b1);
    drive_in(1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp_no_dup%0d", k), 32'(bus0.out_valid), 32'd0);
    end

    // Mid-stream reset with two words in flight.
    @(negedge clk);
    drive_in(1'b1, 32'h4120_0000);
    @(negedge clk);
    drive_in(1'b1, 32'h4130_0000);
    @(negedge clk);
    drive_in(1'b0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_valid0", 32'(bus0.out_valid), 32'd0);
    chk("mrst_data0", bus0.out_data, 32'h0);
    chk("mrst_flags0", 32'(bus0.out_flags), 32'd0);
    chk("mrst_valid1", 32'(bus1.out_valid), 32'd0);
    chk("mrst_data1", bus1.out_data, 32'h0);
    chk("mrst_in_ready", 32'(bus0.in_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("mrst_no_stale0_%0d", k), 32'(bus0.out_valid), 32'd0);
      chk($sformatf("mrst_no_stale1_%0d", k), 32'(bus1.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
